// File: rtl/tdm_wavetable_osc_bank.sv
// tdm_wavetable_osc_bank
// Time-multiplexed bank of wavetable oscillators sharing one table RAM,
// one linear interpolator and one envelope multiplier. A frame_start sweeps
// every voice once through a 4-stage pipeline:
// parameter read -> RAM read -> interpolate -> envelope.
// Optional build macro: OSC_FEEDBACK_EN adds per-voice self-feedback phase
// modulation (cfg_sel 5 sets the feedback amount).
module tdm_wavetable_osc_bank #(
  parameter int P_WIDTH  = 32,
  parameter int D_WIDTH  = 16,
  parameter int A_WIDTH  = 12,
  parameter int N_VOICES = 8,
  parameter int INTERP_W = 16,
  localparam int V_WIDTH = $clog2(N_VOICES)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_start,
  output logic               busy,
  output logic               overrun,
  input  logic               cfg_we,
  input  logic [V_WIDTH-1:0] cfg_voice,
  input  logic [2:0]         cfg_sel,
  input  logic [P_WIDTH-1:0] cfg_data,
  input  logic               wt_we,
  input  logic [A_WIDTH-1:0] wt_addr,
  input  logic [D_WIDTH-1:0] wt_data,
  output logic               out_valid,
  output logic [V_WIDTH-1:0] out_voice,
  output logic [D_WIDTH-1:0] out_sample,
  output logic               frame_done
);

  localparam int DW1 = D_WIDTH + 1;
  localparam int PW  = D_WIDTH + INTERP_W + 2;
  localparam int EW  = 2 * D_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [V_WIDTH-1:0]   issue_voice_q;
  logic                 issue_valid, issue_last;

  logic [P_WIDTH-1:0]   f_c_q  [N_VOICES];
  logic [P_WIDTH-1:0]   f_o_q  [N_VOICES];
  logic [P_WIDTH-1:0]   ph_o_q [N_VOICES];
  logic [P_WIDTH-1:0]   acc_q  [N_VOICES];
  logic [D_WIDTH-1:0]   env_q  [N_VOICES];

  logic [P_WIDTH-1:0]   fb_term;
  logic [P_WIDTH-1:0]   phase;

  logic signed [D_WIDTH-1:0] mem [2**A_WIDTH];

  logic                 s1_valid, s2_valid, s3_valid;
  logic [V_WIDTH-1:0]   s1_voice, s2_voice, s3_voice;
  logic [A_WIDTH-1:0]   s1_addr;
  logic [INTERP_W-1:0]  s1_frac, s2_frac;
  logic [D_WIDTH-1:0]   s1_env, s2_env, s3_env;
  logic signed [D_WIDTH-1:0] rd0, rd1, y_q;

  logic signed [DW1-1:0]     diff;
  logic signed [PW-1:0]      prod;
  logic signed [D_WIDTH-1:0] delta, y_next;
  logic signed [EW-1:0]      env_prod;

  assign busy        = (state_q != IDLE);
  assign issue_valid = (state_q == ISSUE);
  assign issue_last  = (issue_voice_q == V_WIDTH'(N_VOICES - 1));

  // Sweep sequencing: IDLE waits for a frame, ISSUE walks the voices, DRAIN waits for the last sample
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = ISSUE;
      ISSUE:   if (issue_last) state_d = DRAIN;
      DRAIN:   if (out_valid && frame_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, voice issue counter and the sticky overrun flag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      issue_voice_q <= '0;
      overrun       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue_valid)
        issue_voice_q <= issue_last ? '0 : issue_voice_q + V_WIDTH'(1);
      if (frame_start && busy)
        overrun <= 1'b1;
    end
  end

  // Per-voice parameters and phase accumulators; a phase-reset write is placed last so it beats the issue update
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N_VOICES; i++) begin
        f_c_q[i]  <= '0;
        f_o_q[i]  <= '0;
        ph_o_q[i] <= '0;
        acc_q[i]  <= '0;
        env_q[i]  <= '0;
      end
    end else begin
      if (issue_valid)
        acc_q[issue_voice_q] <= acc_q[issue_voice_q] + f_c_q[issue_voice_q] + f_o_q[issue_voice_q];
      if (cfg_we) begin
        case (cfg_sel)
          3'd0:    f_c_q[cfg_voice]  <= cfg_data;
          3'd1:    f_o_q[cfg_voice]  <= cfg_data;
          3'd2:    ph_o_q[cfg_voice] <= cfg_data;
          3'd3:    env_q[cfg_voice]  <= cfg_data[D_WIDTH-1:0];
          3'd4:    acc_q[cfg_voice]  <= '0;
          default: ;
        endcase
      end
    end
  end

`ifdef OSC_FEEDBACK_EN
  logic [3:0]                fb_q       [N_VOICES];
  logic signed [D_WIDTH-1:0] last_out_q [N_VOICES];
  logic signed [P_WIDTH-1:0] fb_wide;

  // Feedback amount per voice and the most recent output sample of each voice
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N_VOICES; i++) begin
        fb_q[i]       <= '0;
        last_out_q[i] <= '0;
      end
    end else begin
      if (cfg_we && cfg_sel == 3'd5)
        fb_q[cfg_voice] <= cfg_data[3:0];
      if (out_valid)
        last_out_q[out_voice] <= out_sample;
    end
  end

  // Previous sample scaled into phase units, attenuated by 8-fb octaves; amounts outside 1..8 disable it
  always_comb begin
    fb_wide = {last_out_q[issue_voice_q], {(P_WIDTH-D_WIDTH){1'b0}}};
    fb_term = '0;
    if (fb_q[issue_voice_q] >= 4'd1 && fb_q[issue_voice_q] <= 4'd8)
      fb_term = fb_wide >>> (4'd8 - fb_q[issue_voice_q]);
  end
`else
  assign fb_term = '0;
`endif

  assign phase = acc_q[issue_voice_q] + ph_o_q[issue_voice_q] + fb_term;

  // Stage 1: split the issued phase into table address and interpolation fraction
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_voice <= '0;
      s1_addr  <= '0;
      s1_frac  <= '0;
      s1_env   <= '0;
    end else begin
      s1_valid <= issue_valid;
      s1_voice <= issue_voice_q;
      s1_addr  <= A_WIDTH'(phase >> (P_WIDTH - A_WIDTH));
      s1_frac  <= INTERP_W'(phase >> (P_WIDTH - A_WIDTH - INTERP_W));
      s1_env   <= env_q[issue_voice_q];
    end
  end

  // Wavetable: one write port and two synchronous read ports for adjacent entries (read-before-write)
  always_ff @(posedge Clk) begin
    if (wt_we)
      mem[wt_addr] <= wt_data;
    rd0 <= mem[s1_addr];
    rd1 <= mem[s1_addr + A_WIDTH'(1)];
  end

  // Stage 2: carry control alongside the RAM read
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s2_valid <= 1'b0;
      s2_voice <= '0;
      s2_frac  <= '0;
      s2_env   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_voice <= s1_voice;
      s2_frac  <= s1_frac;
      s2_env   <= s1_env;
    end
  end

  // Linear interpolation; delta may exceed the sample range but s0 + delta always fits, so modular add is exact
  always_comb begin
    diff   = DW1'(rd1) - DW1'(rd0);
    prod   = PW'(diff) * PW'($signed({1'b0, s2_frac}));
    delta  = D_WIDTH'(prod >>> INTERP_W);
    y_next = rd0 + delta;
  end

  // Stage 3: register the interpolated sample
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s3_valid <= 1'b0;
      s3_voice <= '0;
      s3_env   <= '0;
      y_q      <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_voice <= s2_voice;
      s3_env   <= s2_env;
      y_q      <= y_next;
    end
  end

  // Envelope scaling with the unsigned envelope, floor division by 2**D_WIDTH
  always_comb begin
    env_prod = EW'(y_q) * EW'($signed({1'b0, s3_env}));
  end

  // Stage 4: output register and end-of-frame marker
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid  <= 1'b0;
      out_voice  <= '0;
      out_sample <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= s3_valid;
      out_voice  <= s3_voice;
      out_sample <= D_WIDTH'(env_prod >>> D_WIDTH);
      frame_done <= s3_valid && (s3_voice == V_WIDTH'(N_VOICES - 1));
    end
  end

endmodule

// File: doc/tdm_wavetable_osc_bank.md
Name: tdm_wavetable_osc_bank

Overview:
Time-multiplexed bank of N_VOICES wavetable oscillators sharing one wavetable RAM, one interpolator and one envelope multiplier. Each frame_start sweeps every voice once: per-voice phase accumulation with FM and phase-offset inputs, linear interpolation between adjacent table entries, and envelope scaling. It emits one tagged signed sample per voice. Sits between the per-voice parameter/control logic and the FM-matrix mixer.

Parameters:
P_WIDTH, 32, phase accumulator width
D_WIDTH, 16, signed sample and unsigned envelope width
A_WIDTH, 12, wavetable address width (2**A_WIDTH entries)
N_VOICES, 8, voices per frame (>=2)
INTERP_W, 16, fraction bits used by interpolator (<= P_WIDTH-A_WIDTH)

Ports:
Clk  in  1  clock
Reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse, starts a voice sweep
busy  out  1  sweep or pipeline in flight
overrun  out  1  sticky: frame_start seen while busy
cfg_we  in  1  parameter write strobe
cfg_voice  in  clog2(N_VOICES)  voice index for write
cfg_sel  in  3  0 f_c, 1 f_o, 2 ph_o, 3 env, 4 phase reset, 5 feedback shift
cfg_data  in  P_WIDTH  write data (env uses [D_WIDTH-1:0])
wt_we  in  1  wavetable write strobe
wt_addr  in  A_WIDTH  wavetable write address
wt_data  in  D_WIDTH  signed wavetable entry
out_valid  out  1  sample valid
out_voice  out  clog2(N_VOICES)  voice index of sample
out_sample  out  D_WIDTH  signed enveloped sample
frame_done  out  1  pulse coincident with last voice's out_valid

Behaviour:
- Reset: Clk-synchronous, active-high. busy, overrun, out_valid, out_voice, out_sample, frame_done all 0. Per-voice accumulators and parameters cleared. Wavetable contents kept. Reset mid-sweep aborts it; no further out_valid.
- FSM IDLE -> ISSUE on frame_start. ISSUE sends voice 0..N_VOICES-1, one per cycle, then DRAIN. DRAIN -> IDLE when the last voice leaves the pipe. busy = (state != IDLE).
- frame_start while busy: ignored, overrun <= 1 (sticky until Reset).
- Issue of voice v uses parameters as registered before that cycle. A cfg write to v in the same cycle takes effect next frame.
- Phase: p = acc[v] + ph_o[v]; acc[v] <= acc[v] + f_c[v] + f_o[v]. All arithmetic mod 2**P_WIDTH.
- cfg_sel 4 on voice v clears acc[v] (data ignored). If it collides with v's update in the same cycle, the clear wins.
- Address a = p[P_WIDTH-1 -: A_WIDTH]. Fraction fr = p[P_WIDTH-A_WIDTH-1 -: INTERP_W] (truncated).
- Reads: s0 = T[a], s1 = T[(a+1) mod 2**A_WIDTH]. Synchronous read. Read and write of the same address in one cycle returns old data.
- Interpolation: y = s0 + (((s1-s0) * fr) >>> INTERP_W), full-precision signed, y fits D_WIDTH.
- Envelope: out_sample = (y * env) >>> D_WIDTH, env unsigned, truncation toward -inf.
- Latency: fixed 4 cycles from issue to out_valid (param read, RAM read, interpolate, envelope). Voices are output in order 0..N-1, one per consecutive cycle.
- cfg_sel values 6 and 7 are ignored.

Optional Feature:
OSC_FEEDBACK_EN
- Defined: per-voice 4-bit fb[v] via cfg_sel 5 (cfg_data[3:0]) plus stored last_out[v].
- p gains (sext(last_out[v]) << (P_WIDTH-D_WIDTH)) >>> (8-fb[v]) for fb 1..8. fb 0 or >8 adds nothing.
- last_out[v] updates on each out_valid for v and clears on Reset.
- Undefined: cfg_sel 5 ignored, no last_out storage, behaviour identical to fb = 0.

Test Plan:
- Ramp T[i]=8*i; voice 0 f_c=0x0010_0000, env=0x8000; frames 1,2,3 -> voice 0 out_sample 0, 4, 8. Others env=0 -> 0. Each frame gives 8 out_valid, out_voice 0..7, frame_done on voice 7, first out_valid 4 cycles after sweep issue.
- Interpolation: same table, f_c=0x0008_0000, env=0x8000 -> frame 2 out_sample 2 (y=4).
- Wrap: ph_o=0xFFF8_0000, f_c=0, env=0xFFFF -> a=4095, s1=T[0]=0, y=16380, out_sample 16379 every frame.
- frame_start pulsed again 3 cycles into sweep -> overrun=1, still exactly 8 samples. Reset mid-sweep -> out_valid stays 0, overrun=0, busy=0.
- cfg_sel 4 on voice 0 after 5 frames at f_c=0x0010_0000 -> next frame output 0. Collision with voice 0 issue -> acc stays 0.
- OSC_FEEDBACK_EN, fb=0 -> outputs bit-identical to macro undefined. fb=8 with constant last_out=0x4000 -> address advances by 0x400 extra entries.
